// File: rtl/quad_encoder_pkg.sv
// rtl/quad_encoder_pkg.sv - register map constants and x4 decode helpers for quad_encoder_mc
package quad_encoder_pkg;

  localparam logic [1:0] BANK_LIVE = 2'd0;
  localparam logic [1:0] BANK_SNAP = 2'd1;
  localparam logic [1:0] BANK_STAT = 2'd2;
  localparam logic [1:0] BANK_CTRL = 2'd3;

  localparam int CTRL_SNAP = 0;
  localparam int CTRL_CLR  = 1;
  localparam int CTRL_INFO = 2;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ERR
  } step_e;

  // Position along the forward cycle 00 -> 10 -> 11 -> 01, {A,B} order.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] diff;
    diff = gray_pos(cur_ab) - gray_pos(prev_ab);
    case (diff)
      2'd0:    return STEP_NONE;
      2'd1:    return STEP_INC;
      2'd3:    return STEP_DEC;
      default: return STEP_ERR;
    endcase
  endfunction

endpackage

// File: rtl/quad_encoder_chan.sv
// rtl/quad_encoder_chan.sv - one encoder channel: synchroniser, glitch filter, x4 decode, counter, dir, err
module quad_encoder_chan
  import quad_encoder_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int FILTER_LEN = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 a_i,
  input  logic                 b_i,
  input  logic                 clr_i,
  input  logic                 err_clr_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 dir_o,
  output logic                 err_o
);

  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           filt_q, filt_d;
  logic [1:0]           prev_q;
  logic [3:0]           fcnt_q [2];
  logic [3:0]           fcnt_d [2];
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  step_e                step;

  // Bit 1 is phase A, bit 0 is phase B throughout.
  always_comb begin
    filt_d = filt_q;
    for (int p = 0; p < 2; p++) begin
      fcnt_d[p] = '0;
      if (sync2_q[p] != filt_q[p]) begin
        if (fcnt_q[p] + 4'd1 >= 4'(FILTER_LEN)) filt_d[p] = sync2_q[p];
        else                                     fcnt_d[p] = fcnt_q[p] + 4'd1;
      end
    end
  end

  assign step = decode_step(prev_q, filt_q);

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    err_d   = err_q;
    case (step)
      STEP_INC: begin
        count_d = count_q + CNT_WIDTH'(1);
        dir_d   = 1'b1;
      end
      STEP_DEC: begin
        count_d = count_q - CNT_WIDTH'(1);
        dir_d   = 1'b0;
      end
      default: ;
    endcase
    if (clr_i) count_d = '0;
    if (step == STEP_ERR) err_d = 1'b1;
    else if (err_clr_i)   err_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
      prev_q    <= '0;
      count_q   <= '0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= {a_i, b_i};
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      fcnt_q[0] <= fcnt_d[0];
      fcnt_q[1] <= fcnt_d[1];
      prev_q    <= filt_q;
      count_q   <= count_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

  assign count_o = count_q;
  assign dir_o   = dir_q;
  assign err_o   = err_q;

endmodule

// File: rtl/quad_encoder_mc.sv
// rtl/quad_encoder_mc.sv - multi-channel quadrature encoder counter with Avalon-MM register port
module quad_encoder_mc
  import quad_encoder_pkg::*;
#(
  parameter int CHANNELS   = 11,
  parameter int CNT_WIDTH  = 32,
  parameter int FILTER_LEN = 4,
  parameter int CH_AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [CHANNELS-1:0] encoder_a,
  input  logic [CHANNELS-1:0] encoder_b,
  input  logic [CH_AW+1:0]    avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata
);

  logic [1:0]           bank;
  logic [CH_AW-1:0]     ch;
  logic [31:0]          ch_w;
  logic                 snap_we;
  logic [CHANNELS-1:0]  clr_mask;
  logic [CHANNELS-1:0]  err_clr;
  logic [CHANNELS-1:0]  dir_w, err_w;
  logic [CNT_WIDTH-1:0] cnt_w  [CHANNELS];
  logic [CNT_WIDTH-1:0] snap_q [CHANNELS];
  logic [31:0]          rdata_q, rdata_d;
  logic                 unused_wdata;

  assign {bank, ch} = avs_address;
  assign ch_w       = {{(32 - CH_AW){1'b0}}, ch};
  assign snap_we    = avs_write && bank == BANK_CTRL && ch_w == 32'(CTRL_SNAP) && avs_writedata[0];
  assign clr_mask   = (avs_write && bank == BANK_CTRL && ch_w == 32'(CTRL_CLR))
                      ? avs_writedata[CHANNELS-1:0] : '0;
  assign unused_wdata = ^avs_writedata;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign err_clr[i] = avs_write && bank == BANK_STAT && ch_w == 32'(i) && avs_writedata[1];

    quad_encoder_chan #(
      .CNT_WIDTH  (CNT_WIDTH),
      .FILTER_LEN (FILTER_LEN)
    ) u_chan (
      .clk_i     (clk_clk),
      .rst_ni    (reset_reset_n),
      .a_i       (encoder_a[i]),
      .b_i       (encoder_b[i]),
      .clr_i     (clr_mask[i]),
      .err_clr_i (err_clr[i]),
      .count_o   (cnt_w[i]),
      .dir_o     (dir_w[i]),
      .err_o     (err_w[i])
    );
  end

  // Reads see the live state of this cycle, so a same-cycle write is not yet visible.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_w == 32'(i)) begin
        case (bank)
          BANK_LIVE: rdata_d = 32'($signed(cnt_w[i]));
          BANK_SNAP: rdata_d = 32'($signed(snap_q[i]));
          BANK_STAT: rdata_d = {30'b0, err_w[i], dir_w[i]};
          default:   ;
        endcase
      end
    end
    if (bank == BANK_CTRL && ch_w == 32'(CTRL_INFO))
      rdata_d = {12'b0, 4'(FILTER_LEN), 8'(CNT_WIDTH), 8'(CHANNELS)};
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < CHANNELS; i++) snap_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (snap_we) begin
        for (int i = 0; i < CHANNELS; i++) snap_q[i] <= cnt_w[i];
      end
      if (avs_read) rdata_q <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_quad_encoder_mc.sv
// tb/tb_quad_encoder_mc.sv - scoreboard bench for quad_encoder_mc against a behavioural channel model
module tb_quad_encoder_mc;

  localparam int CH   = 11;
  localparam int AW   = 4;
  localparam int FLEN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] enc_a = '0;
  logic [CH-1:0] enc_b = '0;
  logic [AW+1:0] addr = '0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          rd_seen = 1'b0;

  int checks = 0;
  int passed = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  logic [31:0] m_cnt  [CH];
  logic [31:0] m_snap [CH];
  logic        m_dir  [CH];
  logic        m_err  [CH];
  int          pos    [CH];

  always #5 clk = ~clk;

  quad_encoder_mc dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .encoder_a     (enc_a),
    .encoder_b     (enc_b),
    .avs_address   (addr),
    .avs_read      (rd),
    .avs_write     (wr),
    .avs_writedata (wdata),
    .avs_readdata  (rdata)
  );

  always @(posedge clk) rd_seen <= rd;

  always @(negedge clk) begin
    if (rd_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_read got=%08h expected=none", rdata);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (rdata === e) passed++;
        else $display("FAIL %s got=%08h expected=%08h", n, rdata, e);
      end
    end
  end

  function automatic logic [31:0] exp_reg(input int bank, input int ch);
    if (bank == 3) return (ch == 2) ? ((32'(FLEN) << 16) | (32'd32 << 8) | 32'(CH)) : 32'd0;
    if (ch >= CH) return 32'd0;
    case (bank)
      0:       return m_cnt[ch];
      1:       return m_snap[ch];
      default: return {30'b0, m_err[ch], m_dir[ch]};
    endcase
  endfunction

  function automatic void model_write(input int bank, input int ch, input logic [31:0] d);
    if (bank == 2 && ch < CH && d[1]) m_err[ch] = 1'b0;
    if (bank == 3 && ch == 0 && d[0]) begin
      for (int i = 0; i < CH; i++) m_snap[i] = m_cnt[i];
    end
    if (bank == 3 && ch == 1) begin
      for (int i = 0; i < CH; i++) if (d[i]) m_cnt[i] = 32'd0;
    end
  endfunction

  // Movement rule: one step forward counts up, one step back counts down, two steps is illegal.
  function automatic void model_move(input int c, input int newpos);
    int d;
    d = ((newpos - pos[c]) % 4 + 4) % 4;
    if (d == 1) begin m_cnt[c] = m_cnt[c] + 32'd1; m_dir[c] = 1'b1; end
    if (d == 3) begin m_cnt[c] = m_cnt[c] - 32'd1; m_dir[c] = 1'b0; end
    if (d == 2) m_err[c] = 1'b1;
    pos[c] = newpos;
  endfunction

  task automatic set_pins(input int c, input int p);
    enc_a[c] = (p == 1 || p == 2);
    enc_b[c] = (p == 2 || p == 3);
  endtask

  task automatic move(input int c, input int newpos, input int hold);
    @(negedge clk);
    set_pins(c, newpos);
    model_move(c, newpos);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input int bank, input int ch, input logic [31:0] d);
    @(negedge clk);
    addr  = {2'(bank), 4'(ch)};
    wdata = d;
    wr    = 1'b1;
    model_write(bank, ch, d);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic read_check(input int bank, input int ch, input string name);
    @(negedge clk);
    addr = {2'(bank), 4'(ch)};
    rd   = 1'b1;
    exp_q.push_back(exp_reg(bank, ch));
    name_q.push_back($sformatf("%s_b%0d_c%0d", name, bank, ch));
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic bus_rw(input int bank, input int ch, input logic [31:0] d, input string name);
    @(negedge clk);
    addr  = {2'(bank), 4'(ch)};
    wdata = d;
    wr    = 1'b1;
    rd    = 1'b1;
    exp_q.push_back(exp_reg(bank, ch));
    name_q.push_back(name);
    model_write(bank, ch, d);
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic read_all(input string name);
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < CH; c++) read_check(b, c, name);
  endtask

  task automatic pulse_b(input int c, input int len);
    int p2;
    @(negedge clk);
    enc_b[c] = ~enc_b[c];
    repeat (len) @(negedge clk);
    enc_b[c] = ~enc_b[c];
    if (len >= FLEN) begin
      p2 = (pos[c] == 0) ? 3 : (pos[c] == 1) ? 2 : (pos[c] == 2) ? 1 : 0;
      model_move(c, p2);
      model_move(c, 3 - p2 == pos[c] ? pos[c] : (p2 == 3 ? 0 : p2 == 2 ? 1 : p2 == 1 ? 2 : 3));
    end
  endtask

  initial begin
    int c, op, np;
    logic [31:0] r;

    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = '0; m_snap[i] = '0; m_dir[i] = 1'b0; m_err[i] = 1'b0; pos[i] = 0;
    end

    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Reset state and info register
    @(negedge clk);
    addr = {2'd3, 4'd2};
    rd   = 1'b1;
    exp_q.push_back(32'h0004_200B);
    name_q.push_back("info_reg");
    @(negedge clk);
    rd = 1'b0;
    read_all("reset");

    // Ten forward cycles on channel 3
    for (int i = 0; i < 40; i++) move(3, (pos[3] + 1) % 4, 8);
    idle(8);
    read_all("fwd_ch3");

    // Three reverse edges on channel 0 wrap below zero
    for (int i = 0; i < 3; i++) move(0, (pos[0] + 3) % 4, 8);
    idle(8);
    read_check(0, 0, "rev_wrap");
    read_check(2, 0, "rev_dir");

    // Glitch rejection on channel 7
    pulse_b(7, 3);
    idle(4);
    pulse_b(7, FLEN - 1);
    idle(10);
    read_check(0, 7, "glitch_short");
    pulse_b(7, FLEN);
    idle(12);
    read_check(0, 7, "glitch_long");
    read_check(2, 7, "glitch_long_stat");

    // Illegal transition on channel 5 and err clear
    move(5, 2, 10);
    read_check(0, 5, "illegal_cnt");
    read_check(2, 5, "illegal_stat");
    bus_write(2, 5, 32'h2);
    read_check(2, 5, "err_clr");
    move(5, 0, 10);
    bus_rw(2, 5, 32'h2, "rw_same_cycle");
    read_check(2, 5, "err_clr_after_rw");

    // Snapshot then clear with a coincident count step on channel 1
    for (int i = 0; i < 100; i++) move(1, (pos[1] + 1) % 4, 8);
    for (int i = 0; i < 7; i++)   move(2, (pos[2] + 1) % 4, 8);
    idle(4);
    @(negedge clk);
    np = (pos[1] + 1) % 4;
    set_pins(1, np);
    repeat (5) @(negedge clk);
    addr = {2'd3, 4'd0}; wdata = 32'h1; wr = 1'b1;
    model_write(3, 0, 32'h1);
    @(negedge clk);
    addr = {2'd3, 4'd1}; wdata = 32'h2;
    model_move(1, np);
    model_write(3, 1, 32'h2);
    @(negedge clk);
    wr = 1'b0;
    idle(10);
    read_check(1, 1, "snap1");
    read_check(1, 2, "snap2");
    read_check(0, 1, "live1_clr");
    read_check(0, 2, "live2");

    // Randomised traffic
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 9);
      c  = $urandom_range(0, CH - 1);
      if (op <= 3) begin
        r = $urandom_range(0, 9);
        np = (r == 0) ? (pos[c] + 2) % 4 : (r < 5) ? (pos[c] + 1) % 4 : (pos[c] + 3) % 4;
        move(c, np, $urandom_range(8, 12));
      end else if (op == 4) begin
        bus_write(3, 1, $urandom & ((32'd1 << CH) - 1) & 32'h0000_0249);
      end else if (op == 5) begin
        bus_write(3, 0, 32'($urandom_range(0, 1)));
      end else if (op == 6) begin
        bus_write($urandom_range(0, 3), $urandom_range(0, 15), $urandom);
      end else begin
        read_check($urandom_range(0, 3), $urandom_range(0, 15), "rand");
      end
    end
    idle(10);
    read_all("final");
    idle(4);

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
